// File: rtl/tdm_demux_rx_pkg.sv
// rtl/tdm_demux_rx_pkg.sv - shared types and constants for the TDM 2:1 line receiver
//
// Purpose: common definitions used by tdm_demux_rx and tdm_shift_reg.
//   state_t   : receiver FSM state {IDLE, RUN}
//   WIDTH_DEF : default bits per channel word
//   SEL_A/B   : select-line encoding driven to the external buffer mux
package tdm_demux_rx_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_shift_reg.sv
// rtl/tdm_shift_reg.sv - WIDTH-bit MSB-first serial-in shift register
//
// Purpose: collects one channel's serial bits, first bit ending up in the MSB.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q
//   clr   : synchronous clear (takes priority over shift)
//   shift : shift din into the LSB this edge
//   din   : serial input bit
//   q     : current register contents
module tdm_shift_reg
  import tdm_demux_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - TDM 2:1 shared-line receiver with valid/ready word-pair output
//
// Purpose: toggles the mux select every clock, samples the shared line on each
// phase, deserialises channel A (sel=1) and channel B (sel=0) and presents the
// completed word pair with a valid/ready handshake.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   en           : run enable; dropping it discards the partial word
//   bus_in       : shared line, valid in the same cycle as sel_out
//   sel_out      : mux select (1 = channel A, 0 = channel B)
//   out_a, out_b : last accepted word pair
//   valid, ready : output handshake
//   overrun      : sticky flag, a completed pair was dropped
//   overrun_clr  : synchronous clear of overrun (a new drop on the same edge wins)
module tdm_demux_rx
  import tdm_demux_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bus_in,
  output logic             sel_out,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic            sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            shift_a, shift_b, clr_sh, complete;
  logic [WIDTH-1:0] sh_a, sh_b, word_b;
  logic            unused_sh_b_msb;

  // Shift registers are held clear while idle so a restart never sees stale bits.
  assign clr_sh = (state_q == IDLE);

  tdm_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_sh),
    .shift (shift_a),
    .din   (bus_in),
    .q     (sh_a)
  );

  tdm_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_sh),
    .shift (shift_b),
    .din   (bus_in),
    .q     (sh_b)
  );

  // The last B bit is still on the line at the completion edge, so the B word
  // is assembled with it rather than waiting one more cycle.
  assign word_b          = {sh_b[WIDTH-2:0], bus_in};
  assign unused_sh_b_msb = sh_b[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_out;
    cnt_d    = cnt_q;
    shift_a  = 1'b0;
    shift_b  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          sel_d   = SEL_A;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (sel_out == SEL_A) begin
          shift_a = en;
          sel_d   = SEL_B;
        end else begin
          shift_b  = en;
          sel_d    = SEL_A;
          // A completion on the edge that drops en is still delivered.
          complete = (cnt_q == LAST_BIT);
          cnt_d    = complete ? '0 : cnt_q + 1'b1;
        end
        if (!en) begin
          state_d = IDLE;
          sel_d   = SEL_B;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_out <= SEL_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_out <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a   <= '0;
      out_b   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A pair being consumed on the completion edge frees the slot for the new one.
      if (complete && (!valid || ready)) begin
        out_a <= sh_a;
        out_b <= word_b;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (complete && valid && !ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receiving end of the shared-line 2:1 select scheme used by the tristate-buffer mux.
- The block owns the select line and toggles it every clock, so the external buffer mux time-multiplexes two serial sources (channel A on select=1, channel B on select=0) onto one shared line.
- It samples that line each phase and deserialises the two channels into parallel words.
- Completed word pairs are presented with a valid/ready handshake to downstream logic.

Parameters:
- WIDTH, 8, bits per channel word (2 to 32).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low aborts any partial word.
- bus_in  input  1  shared line driven by the external mux; combinationally valid in the same cycle as sel_out.
- sel_out  output  1  mux select: 1 selects channel A, 0 selects channel B.
- out_a  output  WIDTH  last accepted channel-A word, MSB first on the line.
- out_b  output  WIDTH  last accepted channel-B word.
- valid  output  1  out_a/out_b hold an unconsumed word pair.
- ready  input  1  consumer accepts the pair when valid&&ready at a rising edge.
- overrun  output  1  sticky: a completed pair was dropped.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: sel_out=0, out_a=0, out_b=0, valid=0, overrun=0, state=IDLE, bit_cnt=0, shift registers=0. Reset asserted mid-word discards everything immediately.
- IDLE: sel_out=0. At an edge with en=1, go to RUN with sel_out<=1 and bit_cnt<=0.
- RUN, edge with sel_out=1: sh_a <= {sh_a[WIDTH-2:0], bus_in}; sel_out<=0.
- RUN, edge with sel_out=0: sh_b <= {sh_b[WIDTH-2:0], bus_in}; sel_out<=1; bit_cnt<=bit_cnt+1.
- Word complete: when sel_out=0 and bit_cnt=WIDTH-1, that edge produces completed words sh_a and {sh_b[WIDTH-2:0], bus_in}. bit_cnt wraps to 0 and reception continues gap-free while en=1.
- Latency: the first valid rises at edge 2*WIDTH after the edge that sampled en=1 (edge 16 for WIDTH=8).
- Handshake:
  - valid stays high until valid&&ready at an edge, which clears it.
  - Completion with valid=0: load out_a/out_b and set valid.
  - Completion in the same edge as valid&&ready: load the new pair and keep valid=1; no overrun.
  - Completion with valid=1 and ready=0: new pair dropped, outputs unchanged, overrun<=1.
- overrun: cleared by overrun_clr. If set and cleared on the same edge, set wins.
- en deasserted in RUN (sampled at an edge): go to IDLE with sel_out<=0 and bit_cnt<=0. The partial word is discarded; out_a/out_b/valid are unaffected and the handshake still operates in IDLE.
- If en=0 coincides with a completion edge, the completion is still processed, then the block goes to IDLE.
- Outputs change only on clock edges; no combinational path from bus_in to any output.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN};
  - WIDTH default constant;
  - select encoding constants SEL_A=1'b1, SEL_B=1'b0.
- One natural sub-module: tdm_shift_reg (WIDTH-bit MSB-first shift register with shift enable and synchronous clear). Instantiate it once per channel.

Test Plan:
- Reset then en=1, WIDTH=8, A=0xA5, B=0x3C served by a mux model from sel_out -> valid rises at edge 16, out_a=0xA5, out_b=0x3C; sel_out toggles 1,0,1,0 from edge 0.
- Continuous stream, ready=1 always, pairs (0xA5,0x3C),(0xFF,0x00),(0x01,0x80) -> three single-cycle valid pulses 16 cycles apart, correct values, overrun=0.
- ready=0 across two completions (0x11/0x22 then 0x33/0x44) -> outputs hold 0x11/0x22, overrun=1; overrun_clr pulse -> overrun=0.
- ready=1 on the exact completion edge of the next pair -> outputs switch to the new pair, valid stays 1, overrun stays 0.
- en dropped after 5 bit-pairs, then restarted with A=0x5A, B=0xC3 -> no valid for the partial word; next valid exactly 16 edges after restart with 0x5A/0xC3.
- rst_n asserted asynchronously mid-word with valid=1 -> all outputs 0 immediately (before the next edge); no valid until a full word follows release.
